dmem_port_ctrl: RTL and testbench

Sequencer and arbiter for port B of the data BRAM. Shares the port between the CPU load/store stage and the debug/program-loader port. Generates per-byte write enables for sub-word stores. Handles the 1-cycle BRAM read latency, and returns sign- or zero-extended load data with stall and misalignment signalling. Sits between the MEM stage and the BRAM primitive, and replaces direct BRAM driving from the MEM stage.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/load_extract.sv | 24 ++
 rtl/dmem_port_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_port_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-access encodings for the data-BRAM port.
// Also holds the byte-lane mask helper and the port sequencer state type.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_DISABLE   = 2'b00,
    MEM_READ_SEXT = 2'b01,
    MEM_READ_ZEXT = 2'b10,
    MEM_WRITE     = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RD_CPU = 2'b01,
    RD_DBG = 2'b10
  } port_state_e;

  // Cycles a debug request may lose arbitration before it is forced through.
  localparam int unsigned DBG_MAX_WAIT = 8;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      BYTE:     lane_mask = 4'b0001 << lane;
      HALFWORD: lane_mask = 4'b0011 << lane;
      default:  lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Moves the addressed byte/halfword of a BRAM word down to bit 0
// and sign- or zero-extends it to 32 bits.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] doutB,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = doutB >> {lane, 3'b000};
    case (size)
      BYTE:     data = {{24{sext & shifted[7]}}, shifted[7:0]};
      HALFWORD: data = {{16{sext & shifted[15]}}, shifted[15:0]};
      default:  data = doutB;
    endcase
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Port-B sequencer for the data BRAM: arbitrates CPU vs debug access,
// steers sub-word stores and returns extended load data one cycle later.
module dmem_port_ctrl
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_memOp,
  input  logic [1:0]  cpu_memSize,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_misalign,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [12:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        enaB,
  output logic [3:0]  weB,
  output logic [12:0] addrB,
  output logic [31:0] dinB,
  input  logic [31:0] doutB
);

  localparam logic [7:0] WAIT_MAX = 8'(DBG_MAX_WAIT);

  port_state_e state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;

  logic        cpu_valid, cpu_misaligned, cpu_ok, cpu_is_load;
  logic        dbg_win, cpu_issue, dbg_issue;
  logic [31:0] load_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^cpu_addr[31:15];

  load_extract u_load_extract (
    .doutB (doutB),
    .lane  (lane_q),
    .size  (size_q),
    .sext  (sext_q),
    .data  (load_data)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    cpu_valid      = cpu_req && (cpu_memOp != MEM_DISABLE);
    cpu_misaligned = ((cpu_memSize == HALFWORD) && cpu_addr[0]) ||
                     ((cpu_memSize == WORD) && (cpu_addr[1:0] != 2'b00));
    cpu_ok         = cpu_valid && !cpu_misaligned;
    cpu_is_load    = (cpu_memOp == MEM_READ_SEXT) || (cpu_memOp == MEM_READ_ZEXT);

    // Misaligned CPU requests drop out here, so debug can take the port that cycle.
    dbg_win   = dbg_req && (!cpu_ok || (wait_cnt_q == WAIT_MAX));
    cpu_issue = rstn && (state_q == IDLE) && cpu_ok && !dbg_win;
    dbg_issue = rstn && (state_q == IDLE) && dbg_win;

    state_d    = IDLE;
    wait_cnt_d = wait_cnt_q;
    lane_d     = lane_q;
    size_d     = size_q;
    sext_d     = sext_q;

    if (state_q == IDLE) begin
      if (cpu_issue && cpu_is_load) state_d = RD_CPU;
      else if (dbg_issue && !dbg_we) state_d = RD_DBG;
    end

    if (!dbg_req || dbg_issue)   wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 8'd1;

    if (cpu_issue && cpu_is_load) begin
      lane_d = cpu_addr[1:0];
      size_d = cpu_memSize;
      sext_d = (cpu_memOp == MEM_READ_SEXT);
    end

    enaB         = 1'b0;
    weB          = 4'b0000;
    addrB        = '0;
    dinB         = '0;
    dbg_gnt      = 1'b0;
    cpu_stall    = 1'b0;
    cpu_misalign = 1'b0;
    cpu_rvalid   = 1'b0;
    cpu_rdata    = '0;
    dbg_rvalid   = 1'b0;
    dbg_rdata    = '0;

    if (cpu_issue) begin
      enaB  = 1'b1;
      addrB = cpu_addr[14:2];
      if (cpu_memOp == MEM_WRITE) begin
        weB = lane_mask(cpu_memSize, cpu_addr[1:0]);
        case (cpu_memSize)
          BYTE:     dinB = {4{cpu_wdata[7:0]}};
          HALFWORD: dinB = {2{cpu_wdata[15:0]}};
          default:  dinB = cpu_wdata;
        endcase
      end
    end else if (dbg_issue) begin
      enaB    = 1'b1;
      addrB   = dbg_addr;
      weB     = dbg_we ? 4'b1111 : 4'b0000;
      dinB    = dbg_wdata;
      dbg_gnt = 1'b1;
    end

    // Outputs are forced low while reset is held, including a response in flight.
    if (rstn) begin
      cpu_misalign = cpu_valid && cpu_misaligned;
      cpu_stall    = cpu_ok && ((state_q == RD_DBG) ||
                                ((state_q == IDLE) && (dbg_win || cpu_is_load)));
      cpu_rvalid   = (state_q == RD_CPU);
      dbg_rvalid   = (state_q == RD_DBG);
      if (cpu_rvalid) cpu_rdata = load_data;
      if (dbg_rvalid) dbg_rdata = doutB;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      sext_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Directed bench for dmem_port_ctrl with a behavioural 1-cycle-latency BRAM
// on port B; inputs change after the falling edge, outputs are checked 1ns later.
module tb_dmem_port_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_memOp;
  logic [1:0]  cpu_memSize;
  logic [31:0] cpu_wdata;
  logic        cpu_stall, cpu_rvalid, cpu_misalign;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we;
  logic [12:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        enaB;
  logic [3:0]  weB;
  logic [12:0] addrB;
  logic [31:0] dinB;
  logic [31:0] doutB;

  logic [31:0] mem [0:8191];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_port_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_memOp    (cpu_memOp),
    .cpu_memSize  (cpu_memSize),
    .cpu_wdata    (cpu_wdata),
    .cpu_stall    (cpu_stall),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .cpu_misalign (cpu_misalign),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_gnt      (dbg_gnt),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_rdata    (dbg_rdata),
    .enaB         (enaB),
    .weB          (weB),
    .addrB        (addrB),
    .dinB         (dinB),
    .doutB        (doutB)
  );

  // Behavioural BRAM port: byte-masked write, registered read.
  always @(posedge clk) begin
    if (enaB) begin
      for (int i = 0; i < 4; i++)
        if (weB[i]) mem[addrB][i*8 +: 8] <= dinB[i*8 +: 8];
      if (weB == 4'b0000) doutB <= mem[addrB];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu(input logic req, input logic [1:0] op, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req     = req;
    cpu_memOp   = op;
    cpu_memSize = size;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
  endtask

  task automatic dbg(input logic req, input logic we, input logic [12:0] addr,
                     input logic [31:0] wdata);
    dbg_req   = req;
    dbg_we    = we;
    dbg_addr  = addr;
    dbg_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    // Reset with both requesters active: every output must stay low.
    rstn = 1'b0;
    cpu(1'b1, MEM_WRITE, BYTE, 32'h1003, 32'hAB);
    dbg(1'b1, 1'b1, 13'h10, 32'hDEADBEEF);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rst_enaB", enaB, 0);
      chk("rst_weB", weB, 0);
      chk("rst_dbg_gnt", dbg_gnt, 0);
      chk("rst_cpu_stall", cpu_stall, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      next_cycle();
    end

    // Debug write seeds word 0x10 while the CPU is quiet.
    rstn = 1'b1;
    cpu(1'b0, MEM_DISABLE, BYTE, 32'h0, 32'h0);
    #1;
    chk("dbgw_gnt", dbg_gnt, 1);
    chk("dbgw_weB", weB, 4'hF);
    chk("dbgw_addrB", addrB, 32'h10);
    next_cycle();

    // SB 0x1003
    dbg(1'b0, 1'b0, 13'h0, 32'h0);
    cpu(1'b1, MEM_WRITE, BYTE, 32'h1003, 32'hAB);
    #1;
    chk("sb_addrB", addrB, 32'h400);
    chk("sb_weB", weB, 4'b1000);
    chk("sb_dinB", dinB, 32'hABABABAB);
    chk("sb_stall", cpu_stall, 0);
    chk("sb_enaB", enaB, 1);
    next_cycle();

    // SH 0x202
    cpu(1'b1, MEM_WRITE, HALFWORD, 32'h202, 32'h1234);
    #1;
    chk("sh_weB", weB, 4'b1100);
    chk("sh_dinB", dinB, 32'h12341234);
    chk("sh_addrB", addrB, 32'h80);
    next_cycle();

    // SW 0x8001F080 at 0x100
    cpu(1'b1, MEM_WRITE, WORD, 32'h100, 32'h8001F080);
    #1;
    chk("sw_weB", weB, 4'hF);
    chk("sw_addrB", addrB, 32'h40);
    chk("sw_dinB", dinB, 32'h8001F080);
    next_cycle();

    // LB (sign) 0x101: issue then response
    cpu(1'b1, MEM_READ_SEXT, BYTE, 32'h101, 32'h0);
    #1;
    chk("lb_issue_enaB", enaB, 1);
    chk("lb_issue_weB", weB, 0);
    chk("lb_issue_stall", cpu_stall, 1);
    chk("lb_issue_rvalid", cpu_rvalid, 0);
    next_cycle();
    #1;
    chk("lb_rsp_rvalid", cpu_rvalid, 1);
    chk("lb_rsp_rdata", cpu_rdata, 32'hFFFFFFF0);
    chk("lb_rsp_stall", cpu_stall, 0);
    chk("lb_rsp_enaB", enaB, 0);
    next_cycle();

    // LHU 0x102
    cpu(1'b1, MEM_READ_ZEXT, HALFWORD, 32'h102, 32'h0);
    #1;
    chk("lhu_issue_stall", cpu_stall, 1);
    next_cycle();
    #1;
    chk("lhu_rsp_rvalid", cpu_rvalid, 1);
    chk("lhu_rsp_rdata", cpu_rdata, 32'h00008001);
    next_cycle();

    // LW 0x6 is misaligned
    cpu(1'b1, MEM_READ_SEXT, WORD, 32'h6, 32'h0);
    #1;
    chk("mis_flag", cpu_misalign, 1);
    chk("mis_enaB", enaB, 0);
    chk("mis_stall", cpu_stall, 0);
    next_cycle();
    cpu(1'b0, MEM_DISABLE, BYTE, 32'h0, 32'h0);
    #1;
    chk("mis_pulse_end", cpu_misalign, 0);
    chk("mis_no_rvalid", cpu_rvalid, 0);
    next_cycle();

    // Starvation: CPU stores every cycle, debug write held
    cpu(1'b1, MEM_WRITE, WORD, 32'h200, 32'h11);
    dbg(1'b1, 1'b1, 13'h20, 32'h55);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("starve_gnt", dbg_gnt, 0);
      chk("starve_stall", cpu_stall, 0);
      chk("starve_addrB", addrB, 32'h80);
      next_cycle();
    end
    #1;
    chk("force_gnt", dbg_gnt, 1);
    chk("force_stall", cpu_stall, 1);
    chk("force_addrB", addrB, 32'h20);
    chk("force_weB", weB, 4'hF);
    next_cycle();
    #1;
    chk("after_force_gnt", dbg_gnt, 0);
    chk("after_force_stall", cpu_stall, 0);
    next_cycle();

    // Debug read 0x10, CPU LW arrives during RD_DBG
    cpu(1'b0, MEM_DISABLE, BYTE, 32'h0, 32'h0);
    dbg(1'b1, 1'b0, 13'h10, 32'h0);
    #1;
    chk("dbgr_gnt", dbg_gnt, 1);
    chk("dbgr_weB", weB, 0);
    chk("dbgr_addrB", addrB, 32'h10);
    next_cycle();
    dbg(1'b0, 1'b0, 13'h0, 32'h0);
    cpu(1'b1, MEM_READ_ZEXT, WORD, 32'h100, 32'h0);
    #1;
    chk("dbgr_rvalid", dbg_rvalid, 1);
    chk("dbgr_rdata", dbg_rdata, 32'hDEADBEEF);
    chk("dbgr_cpu_stall", cpu_stall, 1);
    chk("dbgr_enaB", enaB, 0);
    next_cycle();
    #1;
    chk("lw_issue_enaB", enaB, 1);
    chk("lw_issue_addrB", addrB, 32'h40);
    chk("lw_issue_stall", cpu_stall, 1);
    chk("lw_issue_dbg_rvalid", dbg_rvalid, 0);
    next_cycle();
    #1;
    chk("lw_rsp_rdata", cpu_rdata, 32'h8001F080);
    chk("lw_rsp_stall", cpu_stall, 0);
    next_cycle();

    // Forced debug write earlier must have landed at word 0x20
    cpu(1'b0, MEM_DISABLE, BYTE, 32'h0, 32'h0);
    dbg(1'b1, 1'b0, 13'h20, 32'h0);
    next_cycle();
    dbg(1'b0, 1'b0, 13'h0, 32'h0);
    #1;
    chk("dbg20_rdata", dbg_rdata, 32'h55);
    next_cycle();

    // Reset during RD_CPU discards the response
    cpu(1'b1, MEM_READ_ZEXT, BYTE, 32'h100, 32'h0);
    #1;
    chk("rstrd_issue_stall", cpu_stall, 1);
    next_cycle();
    rstn = 1'b0;
    #1;
    chk("rstrd_rvalid", cpu_rvalid, 0);
    chk("rstrd_rdata", cpu_rdata, 0);
    chk("rstrd_stall", cpu_stall, 0);
    next_cycle();
    rstn = 1'b1;
    cpu(1'b0, MEM_DISABLE, BYTE, 32'h0, 32'h0);
    #1;
    chk("post_rst_rvalid", cpu_rvalid, 0);
    next_cycle();
    cpu(1'b1, MEM_READ_SEXT, BYTE, 32'h100, 32'h0);
    #1;
    chk("post_rst_issue_stall", cpu_stall, 1);
    next_cycle();
    #1;
    chk("post_rst_rvalid2", cpu_rvalid, 1);
    chk("post_rst_rdata", cpu_rdata, 32'hFFFFFF80);
    next_cycle();
    cpu(1'b0, MEM_DISABLE, BYTE, 32'h0, 32'h0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
